// File: rtl/demux_dist.sv
// 1-to-4 buffered demultiplexer: each lane is a 2-entry FIFO with a valid/ready handshake.
// Define DEMUX_DIST_BCAST_EN to add in_bcast, which pushes one word into all four lanes.
module demux_dist #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
`ifdef DEMUX_DIST_BCAST_EN
  input  logic             in_bcast,
`endif
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [7:0]       lane_count
);

  logic [WIDTH-1:0] mem [4][2];
  logic [1:0]       count [4];
  logic [3:0]       wptr;
  logic [3:0]       rptr;
  logic [3:0]       lane_ok;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic             bcast;

`ifdef DEMUX_DIST_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // A full lane can still accept when its head leaves in the same cycle.
  always_comb begin
    lane_ok   = '0;
    out_valid = '0;
    pop       = '0;
    push      = '0;
    for (int n = 0; n < 4; n++) begin
      lane_ok[n]   = (count[n] != 2'd2) || out_ready[n];
      out_valid[n] = (count[n] != 2'd0);
      pop[n]       = out_valid[n] && out_ready[n];
    end
    in_ready = bcast ? (&lane_ok) : lane_ok[in_sel];
    for (int n = 0; n < 4; n++) begin
      push[n] = in_valid && in_ready && (bcast || (in_sel == n[1:0]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int n = 0; n < 4; n++) begin
        count[n]  <= '0;
        mem[n][0] <= '0;
        mem[n][1] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push[n]) begin
          mem[n][wptr[n]] <= in_data;
          wptr[n]         <= ~wptr[n];
        end
        if (pop[n]) begin
          rptr[n] <= ~rptr[n];
        end
        case ({push[n], pop[n]})
          2'b10:   count[n] <= count[n] + 2'd1;
          2'b01:   count[n] <= count[n] - 2'd1;
          default: count[n] <= count[n];
        endcase
      end
    end
  end

  // Head is always read from storage, so a push into an empty lane shows up one cycle later.
  assign out0_data  = mem[0][rptr[0]];
  assign out1_data  = mem[1][rptr[1]];
  assign out2_data  = mem[2][rptr[2]];
  assign out3_data  = mem[3][rptr[3]];
  assign lane_count = {count[3], count[2], count[1], count[0]};

endmodule
